// File: rtl/game_pkg.sv
// Shared types and constants for the two-player health / round tracker.
package game_pkg;

  localparam int HEALTH_W = 4;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    P1_WINS = 2'b01,
    P2_WINS = 2'b10,
    DRAW    = 2'b11
  } round_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/player_health_unit.sv
// One player's hit edge detect, invulnerability window and health register.
module player_health_unit
  import game_pkg::*;
#(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                hit,
  input  logic                enable,
  input  logic                restart,
  output logic [HEALTH_W-1:0] health,
  output logic                invuln,
  output logic                accepted
);

  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  logic             prev_hit;
  logic [INV_W-1:0] inv_cnt;

  // Restart wins over a hit sampled on the same edge.
  assign accepted = hit & ~prev_hit & (inv_cnt == '0) & enable & ~restart;
  assign invuln   = (inv_cnt != '0);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_hit <= 1'b0;
      health   <= HEALTH_W'(MAX_HEALTH);
      inv_cnt  <= '0;
    end else begin
      // Edge register keeps sampling through restart so held levels never count.
      prev_hit <= hit;
      if (restart) begin
        health  <= HEALTH_W'(MAX_HEALTH);
        inv_cnt <= '0;
      end else if (accepted) begin
        health  <= (health != '0) ? health - HEALTH_W'(1) : '0;
        inv_cnt <= INV_W'(INVULN_FRAMES);
      end else if (inv_cnt != '0) begin
        inv_cnt <= inv_cnt - INV_W'(1);
      end
    end
  end

endmodule

// File: rtl/player_health_tracker.sv
// Round FSM and bullet-clear routing around two player health units.
module player_health_tracker
  import game_pkg::*;
#(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                player_1_hit,
  input  logic                player_2_hit,
  input  logic                restart,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_invuln,
  output logic                p2_invuln,
  output logic                bullet1_clear,
  output logic                bullet2_clear,
  output logic                game_over,
  output logic [1:0]          winner
);

  round_state_t state, state_next;
  logic         enable, acc1, acc2, p1_dead, p2_dead;

  assign enable = (state == PLAYING);

  player_health_unit #(.MAX_HEALTH(MAX_HEALTH), .INVULN_FRAMES(INVULN_FRAMES)) u_p1 (
    .frame_clk(frame_clk), .Reset(Reset), .hit(player_1_hit), .enable(enable),
    .restart(restart), .health(p1_health), .invuln(p1_invuln), .accepted(acc1)
  );

  player_health_unit #(.MAX_HEALTH(MAX_HEALTH), .INVULN_FRAMES(INVULN_FRAMES)) u_p2 (
    .frame_clk(frame_clk), .Reset(Reset), .hit(player_2_hit), .enable(enable),
    .restart(restart), .health(p2_health), .invuln(p2_invuln), .accepted(acc2)
  );

  // Health as it will be after this edge's decrement.
  assign p1_dead = (p1_health == '0) | ((p1_health == HEALTH_W'(1)) & acc1);
  assign p2_dead = (p2_health == '0) | ((p2_health == HEALTH_W'(1)) & acc2);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= PLAYING;
      bullet1_clear <= 1'b0;
      bullet2_clear <= 1'b0;
    end else begin
      state         <= state_next;
      bullet1_clear <= acc2 & ~restart;
      bullet2_clear <= acc1 & ~restart;
    end
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = PLAYING;
    end else if (state == PLAYING) begin
      if (p1_dead && p2_dead)  state_next = DRAW;
      else if (p1_dead)        state_next = P2_WINS;
      else if (p2_dead)        state_next = P1_WINS;
    end
  end

  always_comb begin
    winner = WIN_NONE;
    case (state)
      P1_WINS: winner = WIN_P1;
      P2_WINS: winner = WIN_P2;
      DRAW:    winner = WIN_DRAW;
      default: winner = WIN_NONE;
    endcase
  end

  assign game_over = (state != PLAYING);

endmodule

// File: tb/tb_player_health_tracker.sv
// Random + directed bench for player_health_tracker against a frame-level model.
module tb_player_health_tracker;
  localparam int MAXH = 3;
  localparam int INV  = 4;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       player_1_hit = 1'b0, player_2_hit = 1'b0, restart = 1'b0;
  logic [3:0] p1_health, p2_health;
  logic       p1_invuln, p2_invuln, bullet1_clear, bullet2_clear, game_over;
  logic [1:0] winner;

  player_health_tracker #(.MAX_HEALTH(MAXH), .INVULN_FRAMES(INV)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .player_1_hit(player_1_hit),
    .player_2_hit(player_2_hit), .restart(restart), .p1_health(p1_health),
    .p2_health(p2_health), .p1_invuln(p1_invuln), .p2_invuln(p2_invuln),
    .bullet1_clear(bullet1_clear), .bullet2_clear(bullet2_clear),
    .game_over(game_over), .winner(winner)
  );

  always #5 frame_clk = ~frame_clk;

  int npass = 0, ntot = 0;
  // reference model: health, remaining invuln frames, result code (0 playing,1 P1,2 P2,3 draw)
  int m_h1, m_h2, m_inv1, m_inv2, m_win;
  bit m_p1, m_p2, m_c1, m_c2;

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model(input bit h1, input bit h2, input bit rs, input bit rst);
    bit a1, a2;
    if (rst) begin
      m_h1 = MAXH; m_h2 = MAXH; m_inv1 = 0; m_inv2 = 0; m_win = 0;
      m_p1 = 0; m_p2 = 0; m_c1 = 0; m_c2 = 0;
      return;
    end
    a1 = h1 && !m_p1 && m_inv1 == 0 && m_win == 0 && !rs;
    a2 = h2 && !m_p2 && m_inv2 == 0 && m_win == 0 && !rs;
    m_p1 = h1; m_p2 = h2;
    if (rs) begin
      m_h1 = MAXH; m_h2 = MAXH; m_inv1 = 0; m_inv2 = 0; m_win = 0; m_c1 = 0; m_c2 = 0;
      return;
    end
    if (a1 && m_h1 > 0) m_h1--;
    if (a2 && m_h2 > 0) m_h2--;
    m_inv1 = a1 ? INV : (m_inv1 > 0 ? m_inv1 - 1 : 0);
    m_inv2 = a2 ? INV : (m_inv2 > 0 ? m_inv2 - 1 : 0);
    m_c1 = a2; m_c2 = a1;
    if (m_win == 0 && (m_h1 == 0 || m_h2 == 0))
      m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h1 == 0 ? 2 : 1);
  endtask

  task automatic step(input bit h1, input bit h2, input bit rs, input bit rst);
    player_1_hit = h1; player_2_hit = h2; restart = rs; Reset = rst;
    @(posedge frame_clk);
    model(h1, h2, rs, rst);
    @(negedge frame_clk);
    chk("p1_health", p1_health, m_h1);
    chk("p2_health", p2_health, m_h2);
    chk("p1_invuln", p1_invuln, m_inv1 > 0);
    chk("p2_invuln", p2_invuln, m_inv2 > 0);
    chk("bullet1_clear", bullet1_clear, m_c1);
    chk("bullet2_clear", bullet2_clear, m_c2);
    chk("game_over", game_over, m_win != 0);
    chk("winner", winner, m_win);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int c1, c2;
    bit r1, r2;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_p1_health", p1_health, 3);
    chk("rst_winner", winner, 0);
    chk("rst_game_over", game_over, 0);

    // single P2 hit: decrement, one clear pulse, 4 frames of invuln
    step(0, 1, 0, 0);
    chk("s1_p2_health", p2_health, 2);
    chk("s1_clear", bullet1_clear, 1);
    chk("s1_p1_health", p1_health, 3);
    step(0, 0, 0, 0);
    chk("s1_clear_once", bullet1_clear, 0);
    idle(2);
    chk("s1_inv_last", p2_invuln, 1);
    step(0, 0, 0, 0);
    chk("s1_inv_end", p2_invuln, 0);

    // held level counts once
    step(0, 0, 0, 1);
    c2 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      c2 += bullet2_clear;
    end
    chk("held_health", p1_health, 2);
    chk("held_clear_cnt", c2, 1);
    idle(1);

    // pulses at frames 0, 2, 6
    step(0, 0, 0, 1);
    for (int f = 0; f <= 6; f++) step(f == 0 || f == 2 || f == 6, 0, 0, 0);
    chk("spaced_health", p1_health, 1);

    // P2 killed by three spaced hits, then hits ignored
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin step(0, 1, 0, 0); idle(5); end
    chk("p1win_winner", winner, 1);
    for (int k = 0; k < 2; k++) begin step(1, 1, 0, 0); idle(5); end
    chk("p1win_hold", p1_health, 3);

    // draw from 1/1
    step(0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin step(1, 1, 0, 0); idle(5); end
    step(1, 1, 0, 0);
    chk("draw_winner", winner, 3);
    chk("draw_clr1", bullet1_clear, 1);
    chk("draw_clr2", bullet2_clear, 1);
    idle(1);

    // mid-round restart with a hit rising on the same frame
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); idle(5);
    step(1, 0, 1, 0);
    chk("rs_health", p1_health, 3);
    chk("rs_invuln", p1_invuln, 0);
    step(1, 0, 0, 0);
    chk("rs_held", p1_health, 3);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rs_rearm", p1_health, 2);

    // random levels, occasional restart / reset
    r1 = 0; r2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r1 = ~r1;
      if ($urandom_range(3) == 0) r2 = ~r2;
      step(r1, r2, $urandom_range(60) == 0, $urandom_range(300) == 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
